// File: rtl/vme_slave_if.sv
// VME slave responder: decodes a word address window, runs a byte-lane-qualified
// read or write on a local 32-bit memory after programmable wait states, then handshakes.
module vme_slave_if #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        as_n,
  input  logic        ds0_n,
  input  logic        ds1_n,
  input  logic        write_n,
  output logic [31:0] data_out,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_addr;
  logic [31:0]           r_data;
  logic                  r_write_n;
  logic                  r_ds0_n;
  logic                  r_ds1_n;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_latch;
  logic                  w_access;
  logic [32:0]           w_diff;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_rd_masked;
  logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

  // Bit 32 of the widened difference is the borrow, i.e. address below the window.
  assign w_diff      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
  assign w_hit       = !w_diff[32] && (w_diff[31:ADDR_WIDTH] == '0);
  assign w_idx       = w_diff[ADDR_WIDTH-1:0];
  assign w_rd_word   = r_mem[w_idx];
  assign w_rd_masked = {r_ds1_n ? 16'h0000 : w_rd_word[31:16],
                        r_ds0_n ? 16'h0000 : w_rd_word[15:0]};

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!as_n && (!ds0_n || !ds1_n)) begin
          w_next  = S_DECODE;
          w_latch = 1'b1;
        end
      end
      S_DECODE: begin
        if (as_n) begin
          w_next = S_IDLE;
        end else if (!w_hit) begin
          w_next = S_ERR;
        end else if (WAIT_STATES == 0) begin
          w_next   = S_ACK;
          w_access = 1'b1;
        end else begin
          w_next     = S_WAIT;
          w_cnt_next = 4'(WAIT_STATES - 1);
        end
      end
      S_WAIT: begin
        if (as_n) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next   = S_ACK;
          w_access = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_ACK, S_ERR: begin
        if (as_n) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 32'h0000_0000;
      r_data    <= 32'h0000_0000;
      r_write_n <= 1'b1;
      r_ds0_n   <= 1'b1;
      r_ds1_n   <= 1'b1;
      data_out  <= 32'h0000_0000;
      dtack_n   <= 1'b1;
      berr_n    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr    <= address;
        r_data    <= data_in;
        r_write_n <= write_n;
        r_ds0_n   <= ds0_n;
        r_ds1_n   <= ds1_n;
      end
      dtack_n <= (w_next != S_ACK);
      berr_n  <= (w_next != S_ERR);
      busy    <= (w_next != S_IDLE);
      if (w_access && r_write_n) begin
        data_out <= w_rd_masked;
      end
    end
  end

  // Memory sits outside the reset domain so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_access && !r_write_n) begin
      if (!r_ds0_n) begin
        r_mem[w_idx][15:0] <= r_data[15:0];
      end
      if (!r_ds1_n) begin
        r_mem[w_idx][31:16] <= r_data[31:16];
      end
    end
  end

endmodule

// File: tb/tb_vme_slave_if.sv
// Scoreboard bench for vme_slave_if: expected handshakes are queued by the stimulus
// and matched by a monitor on each falling dtack_n/berr_n; a second instance runs with no wait states.
module tb_vme_slave_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        as_n = 1'b1;
  logic        as0_n = 1'b1;
  logic        ds0_n = 1'b1;
  logic        ds1_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] data_out, data_out0;
  logic        dtack_n, berr_n, busy;
  logic        dtack0_n, berr0_n, busy0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   prev_dtack = 1'b1;
  bit   prev_berr = 1'b1;

  vme_slave_if #(.BASE_ADDR(32'h0), .ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .as_n(as_n),
    .ds0_n(ds0_n), .ds1_n(ds1_n), .write_n(write_n), .data_out(data_out),
    .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy));

  vme_slave_if #(.BASE_ADDR(32'h0), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .as_n(as0_n),
    .ds0_n(ds0_n), .ds1_n(ds1_n), .write_n(write_n), .data_out(data_out0),
    .dtack_n(dtack0_n), .berr_n(berr0_n), .busy(busy0));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pop one expectation on every new handshake of the wait-state instance.
  always @(negedge clk) begin
    if (!dtack_n && !berr_n) chk("dtack_berr_exclusive", 32'd1, 32'd0);
    if ((!dtack_n && prev_dtack) || (!berr_n && prev_berr)) begin
      if (q.size() == 0) begin
        chk("unexpected_handshake", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("handshake_kind", {31'd0, !berr_n}, {31'd0, e.is_err});
        chk("handshake_cycle", cyc, e.cyc);
        if (!e.is_err && e.chk_data) chk("read_data", data_out, e.data);
      end
    end
    prev_dtack = dtack_n;
    prev_berr  = berr_n;
  end

  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input bit wr_n,
                           input bit d0n, input bit d1n, input bit exp_err,
                           input logic [31:0] exp_d, input bit chk_d);
    exp_t e;
    bit   got;
    @(negedge clk);
    address = a; data_in = d; write_n = wr_n; ds0_n = d0n; ds1_n = d1n; as_n = 1'b0;
    e.is_err = exp_err; e.data = exp_d; e.chk_data = chk_d;
    e.cyc = cyc + 1 + (exp_err ? 1 : 3);
    q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!dtack_n || !berr_n) got = 1'b1;
    end
    if (!got) chk("handshake_timeout", 32'd0, 32'd1);
    if (exp_err) chk("err_no_dtack", {31'd0, dtack_n}, 32'd1);
    as_n = 1'b1; ds0_n = 1'b1; ds1_n = 1'b1;
    @(negedge clk);
    chk("release", {29'd0, dtack_n, berr_n, busy}, {29'd0, 3'b110});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {29'd0, dtack_n, berr_n, busy}, {29'd0, 3'b110});
    chk("reset_data", data_out, 32'h0);
    chk("reset_outputs0", {29'd0, dtack0_n, berr0_n, busy0}, {29'd0, 3'b110});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    bus_cycle(32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    bus_cycle(32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    bus_cycle(32'd5, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    bus_cycle(32'd5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_BEEF, 1'b1);
    bus_cycle(32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_BEEF, 1'b1);
    bus_cycle(32'h400, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("err_keeps_data_out", data_out, 32'h1234_BEEF);
    bus_cycle(32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_BEEF, 1'b1);

    // Address strobe without data strobes must not start a cycle.
    @(negedge clk);
    as_n = 1'b0; ds0_n = 1'b1; ds1_n = 1'b1; address = 32'd5;
    repeat (3) @(negedge clk);
    chk("as_only_idle", {31'd0, busy}, 32'd0);
    as_n = 1'b1;
    @(negedge clk);

    // Abort during WAIT leaves memory untouched.
    bus_cycle(32'd7, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    address = 32'd7; data_in = 32'hFFFF_FFFF; write_n = 1'b0; ds0_n = 1'b0; ds1_n = 1'b0; as_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    as_n = 1'b1; ds0_n = 1'b1; ds1_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {30'd0, busy, dtack_n}, 32'd1);
    repeat (3) @(negedge clk);
    bus_cycle(32'd7, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1);

    // Reset in the middle of WAIT.
    @(negedge clk);
    address = 32'd5; data_in = 32'h5555_AAAA; write_n = 1'b0; ds0_n = 1'b0; ds1_n = 1'b0; as_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {29'd0, dtack_n, berr_n, busy}, {29'd0, 3'b110});
    chk("rst_async_data", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0; as_n = 1'b1; ds0_n = 1'b1; ds1_n = 1'b1;
    @(negedge clk);
    bus_cycle(32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_BEEF, 1'b1);

    // Zero wait states: dtack_n falls one edge after the strobe sample.
    @(negedge clk);
    address = 32'd3; data_in = 32'hCAFE_0001; write_n = 1'b0; ds0_n = 1'b0; ds1_n = 1'b0; as0_n = 1'b0;
    @(negedge clk);
    chk("ws0_write_not_yet", {31'd0, dtack0_n}, 32'd1);
    @(negedge clk);
    chk("ws0_write_dtack", {30'd0, dtack0_n, berr0_n}, 32'd1);
    as0_n = 1'b1; ds0_n = 1'b1; ds1_n = 1'b1;
    @(negedge clk);
    chk("ws0_release", {31'd0, dtack0_n}, 32'd1);
    @(negedge clk);
    write_n = 1'b1; ds0_n = 1'b0; ds1_n = 1'b0; as0_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("ws0_read_dtack", {31'd0, dtack0_n}, 32'd0);
    chk("ws0_read_data", data_out0, 32'hCAFE_0001);
    as0_n = 1'b1; ds0_n = 1'b1; ds1_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
